// File: rtl/button_conditioner.sv
// Per-channel 2-FF synchronizer, debouncer and edge/long-hold pulse generator for push buttons.
// The release pulse port is named release_pulse because `release` is a reserved SystemVerilog word.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] hold
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DcntLast = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HcntMax  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HcntPre  = HW'(HOLD_CYCLES - 1);

  logic [NUM_BTN-1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          press_q, release_q, hold_q;
    logic          stay_high;

    always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      if (s2_q[i] != level_q) begin
        if (dcnt_q == DcntLast) begin
          level_d = s2_q[i];
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      // Count only while level stays high across the edge so a falling edge never yields hold.
      stay_high = level_q & level_d;
      hcnt_d    = '0;
      if (stay_high) begin
        hcnt_d = (hcnt_q == HcntMax) ? hcnt_q : hcnt_q + HW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
      end else begin
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        level_q   <= level_d;
        press_q   <= level_d & ~level_q;
        release_q <= ~level_d & level_q;
        hold_q    <= stay_high & (hcnt_q == HcntPre);
      end
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
    assign hold[i]          = hold_q;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side conditioner for the reaction-time game's push buttons. It synchronizes `NUM_BTN` asynchronous raw button pins into the `clk` domain and debounces each one independently. Per channel it produces a clean level, a one-cycle press pulse, a one-cycle release pulse and a one-cycle long-hold pulse. It sits between the board pins and the reaction FSM; the FSM consumes only the pulses and never sees raw pins.

## Interface

- `NUM_BTN`, default 3: number of independent button channels (bit 0 = reset, 1 = go, 2 = react at top level).
- `DEBOUNCE_CYCLES`, default 250000: consecutive synchronized cycles a new value must persist before it is accepted. Must be ≥1.
- `HOLD_CYCLES`, default 25000000: cycles of accepted-high level before `hold` pulses. Must be ≥1.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high; clears all state on the next `clk` rising edge.
- `btn_raw`  in  NUM_BTN  asynchronous raw button inputs, active-high.
- `level`  out  NUM_BTN  debounced, registered button state.
- `press`  out  NUM_BTN  one-cycle pulse on accepted 0→1.
- `release`  out  NUM_BTN  one-cycle pulse on accepted 1→0.
- `hold`  out  NUM_BTN  one-cycle pulse when `level` has been high for HOLD_CYCLES cycles.

## Operation

- **Per-channel pipeline:** 2-FF synchronizer (`s1`, `s2`) → debounce counter `dcnt` → `level` register → hold counter `hcnt`. Channels share no state.
- **Debounce, evaluated each edge:**
  - If `s2 == level`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `level <= s2`, `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
- **Glitch rejection:** any return of `s2` to `level` before acceptance clears `dcnt`, so `level`, `press` and `release` are unaffected.
- **Pulses:** `press` and `release` are registered. They assert high in the same cycle that `level` changes and clear on the next edge. A pulse therefore coincides with the first cycle of the new `level` value.
- **Hold counter:**
  - `hcnt` clears whenever `level` is 0.
  - While `level` is 1, `hcnt` increments and saturates at HOLD_CYCLES.
  - `hold` pulses for one cycle on the edge where `hcnt` goes HOLD_CYCLES-1 → HOLD_CYCLES.
  - Exactly one `hold` per press, however long the button is held.
  - A release before saturation produces no `hold`.
- **Widths:**
  - `dcnt` width = max(1, $clog2(DEBOUNCE_CYCLES)).
  - `hcnt` width = $clog2(HOLD_CYCLES+1).
  - Counters never wrap.
- **Reset:**
  - Clears `s1`, `s2`, `dcnt`, `hcnt`, `level`, `press`, `release` and `hold` to 0. These are also the reset values of all outputs.
  - Reset mid-count discards progress.
  - A button held through reset is treated as a fresh press after reset deasserts.
  - Reset has priority over all other updates in the same cycle.
- **Simultaneous events:** multiple channels may pulse in the same cycle. Each channel's behaviour is identical to isolated operation.

## Timing

- Edge numbering: edge 0 is the first rising edge that samples `btn_raw[i]` = 1 into `s1`, with `reset` low.
- `s2` is 1 after edge 1. `dcnt` counts on edges 2 .. DEBOUNCE_CYCLES+1.
- `level[i]` and `press[i]` go high after edge DEBOUNCE_CYCLES+1. Latency is DEBOUNCE_CYCLES+2 cycles from the first sampling edge.
- Release has the same latency: `release` pulse and `level` low after edge DEBOUNCE_CYCLES+1, counted from the first edge sampling 0.
- `hold[i]` is high during the cycle after edge DEBOUNCE_CYCLES+1+HOLD_CYCLES, provided `level` stays 1 throughout.
- DEBOUNCE_CYCLES = 1: `level` follows `s2` with one cycle of delay.
- Release pulse and hold pulse can never coincide, because `hcnt` clears when `level` falls.
- No combinational path from any input to any output.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, NUM_BTN=3.

1. **Clean press:** `btn_raw[1]` 0→1 held 20 cycles → `level[1]`=1 and `press[1]`=1 for exactly one cycle, 6 cycles after the first sampling edge. Channels 0 and 2 stay 0.
2. **Bounce:** `btn_raw[2]` toggles 1,0,1,1,0 (one cycle each), then holds 1 → no pulse during the bounce. Exactly one `press[2]` 6 cycles after the final stable 1 is first sampled.
3. **Glitch:** `btn_raw[0]` high for 3 cycles then low → `level[0]`, `press[0]` and `release[0]` remain 0 throughout.
4. **Hold and release:** `btn_raw[1]` high 30 cycles, then low → one `press[1]`, one `hold[1]` exactly 10 cycles after `press[1]`, no second `hold`. One `release[1]` 6 cycles after the falling sample.
5. **Reset mid-operation:** `btn_raw[0]` held high; pulse `reset` for 1 cycle while `dcnt` = 2 → all outputs 0 the cycle after reset. `press[0]` fires 6 cycles after the first post-reset sampling edge.
6. **Simultaneous:** all three raw inputs rise on the same edge → `press` = 3'b111 for one cycle, then `level` = 3'b111.
